exec_cc_stage: RTL and testbench

- Execute stage of the pipeline. It sits directly downstream of the decode/register-read stage and wraps the existing 64-bit signed adder `add_64`.
- Performs the ALU operation and maintains the condition-code register (ZF, SF, OF).
- Evaluates branch/cmov conditions against the current flags.
- Presents the registered result to the memory stage through a valid/ready handshake.

---
 rtl/exec_cc_stage_pkg.sv | 22 ++
 rtl/add_64.sv | 11 +
 rtl/exec_cc_stage_cond_eval.sv | 32 +++
 rtl/exec_cc_stage.sv | 106 ++++++++++
 tb/tb_exec_cc_stage.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_cc_stage_pkg.sv
// Shared codes for the execute stage: ALU functions, condition selectors
// and condition-code bit positions.
package exec_cc_stage_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_LE     = 4'd1;
  localparam logic [3:0] COND_L      = 4'd2;
  localparam logic [3:0] COND_E      = 4'd3;
  localparam logic [3:0] COND_NE     = 4'd4;
  localparam logic [3:0] COND_GE     = 4'd5;
  localparam logic [3:0] COND_G      = 4'd6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

endpackage

// File: rtl/add_64.sv
// Fixed-width 64-bit adder with carry-in, shared by add and subtract.
module add_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum
);

  assign sum = a + b + {63'd0, cin};

endmodule

// File: rtl/exec_cc_stage_cond_eval.sv
// Branch/cmov condition evaluation against a {ZF,SF,OF} flag vector.
module cond_eval
  import exec_cc_stage_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] cond_fun,
  output logic       cnd
);

  logic zf;
  logic sf;
  logic of;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    case (cond_fun)
      COND_ALWAYS: cnd = 1'b1;
      COND_LE:     cnd = (sf ^ of) | zf;
      COND_L:      cnd = sf ^ of;
      COND_E:      cnd = zf;
      COND_NE:     cnd = !zf;
      COND_GE:     cnd = !(sf ^ of);
      COND_G:      cnd = !(sf ^ of) && !zf;
      default:     cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute stage: ALU around add_64, condition-code register, condition
// evaluation on the pre-update flags, and a one-deep valid/ready output register.
module exec_cc_stage
  import exec_cc_stage_pkg::*;
#(
  parameter int         DATA_W   = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_fun,
  input  logic [3:0]        cond_fun,
  input  logic [DATA_W-1:0] aluA,
  input  logic [DATA_W-1:0] aluB,
  input  logic              set_cc,
  input  logic              bubble,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] valE,
  output logic              cnd,
  output logic [2:0]        cc,
  output logic              err
);

  logic        is_sub;
  logic [63:0] add_b;
  logic [63:0] sum;
  logic [63:0] result;
  logic        ovf;
  logic        fun_ok;
  logic [2:0]  flags;
  logic        cnd_now;
  logic        accept;

  // Subtraction reuses the adder as B + ~A + 1.
  assign is_sub = (alu_fun == ALU_SUB);
  assign add_b  = is_sub ? ~aluA : aluA;

  add_64 u_add (
    .a   (aluB),
    .b   (add_b),
    .cin (is_sub),
    .sum (sum)
  );

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    fun_ok = 1'b1;
    case (alu_fun)
      ALU_ADD: begin
        result = sum;
        ovf    = (aluA[63] == aluB[63]) && (sum[63] != aluB[63]);
      end
      ALU_SUB: begin
        result = sum;
        ovf    = (aluA[63] != aluB[63]) && (sum[63] != aluB[63]);
      end
      ALU_AND: result = aluA & aluB;
      ALU_XOR: result = aluA ^ aluB;
      default: fun_ok = 1'b0;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[CC_ZF] = (result == '0);
    flags[CC_SF] = result[63];
    flags[CC_OF] = ovf;
  end

  // Conditions see the flags as they stand before this instruction updates them.
  cond_eval u_cond (
    .cc       (cc),
    .cond_fun (cond_fun),
    .cnd      (cnd_now)
  );

  assign in_ready = !bubble && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      valE      <= '0;
      cnd       <= 1'b0;
      err       <= 1'b0;
      cc        <= CC_RESET;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        valE      <= result;
        cnd       <= cnd_now;
        err       <= !fun_ok;
        if (set_cc && fun_ok) begin
          cc <= flags;
        end
      end else if (bubble || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_cc_stage.sv
// Self-checking bench for exec_cc_stage: directed vector table, hand-written
// handshake/reset sequences and a randomized run against a flag-level model.
module tb_exec_cc_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_fun;
  logic [3:0]  cond_fun;
  logic [63:0] aluA;
  logic [63:0] aluB;
  logic        set_cc;
  logic        bubble;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valE;
  logic        cnd;
  logic [2:0]  cc;
  logic        err;

  int checks = 0;
  int errors = 0;

  exec_cc_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_fun   (alu_fun),
    .cond_fun  (cond_fun),
    .aluA      (aluA),
    .aluB      (aluB),
    .set_cc    (set_cc),
    .bubble    (bubble),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .valE      (valE),
    .cnd       (cnd),
    .cc        (cc),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  fun;
    logic [3:0]  cond;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [63:0] exp_val;
    logic [2:0]  exp_cc;
    logic        exp_cnd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] f, input logic [3:0] c, input logic [63:0] a,
                       input logic [63:0] b, input logic s);
    alu_fun  = f;
    cond_fun = c;
    aluA     = a;
    aluB     = b;
    set_cc   = s;
  endtask

  // Reference ALU: signed overflow taken from 65-bit exact arithmetic.
  function automatic void ref_alu(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [2:0] fl, output logic ok);
    logic signed [64:0] wide;
    logic of;
    ok = 1'b1;
    of = 1'b0;
    r  = '0;
    case (f)
      4'd0: begin
        wide = $signed({b[63], b}) + $signed({a[63], a});
        r = wide[63:0];
        of = wide[64] != wide[63];
      end
      4'd1: begin
        wide = $signed({b[63], b}) - $signed({a[63], a});
        r = wide[63:0];
        of = wide[64] != wide[63];
      end
      4'd2: r = a & b;
      4'd3: r = a ^ b;
      default: ok = 1'b0;
    endcase
    fl = {r == 64'd0, r[63], of};
  endfunction

  function automatic logic ref_cond(input logic [3:0] c, input logic [2:0] f);
    logic z, s, o;
    z = f[2];
    s = f[1];
    o = f[0];
    case (c)
      4'd0: return 1'b1;
      4'd1: return (s != o) || z;
      4'd2: return s != o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return s == o;
      4'd6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    logic [63:0] m_val;
    logic        m_valid;
    logic        m_cnd;
    logic        m_err;
    logic [2:0]  m_cc;
    logic [63:0] r;
    logic [2:0]  fl;
    logic        ok;
    logic        exp_rdy;
    int          delivered;

    vecs[0] = '{4'd0, 4'd0, 64'd1012138011, 64'd5, 1'b1, 64'd1012138016, 3'b000, 1'b1, 1'b0};
    vecs[1] = '{4'd0, 4'd3, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 3'b011, 1'b0, 1'b0};
    vecs[2] = '{4'd1, 4'd2, 64'd10, 64'd10, 1'b1, 64'd0, 3'b100, 1'b0, 1'b0};
    vecs[3] = '{4'd2, 4'd1, 64'hFF, 64'h0F, 1'b0, 64'h0F, 3'b100, 1'b1, 1'b0};
    vecs[4] = '{4'd3, 4'd4, 64'd5, 64'd5, 1'b1, 64'd0, 3'b100, 1'b0, 1'b0};
    vecs[5] = '{4'd1, 4'd5, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1'b1, 1'b0};
    vecs[6] = '{4'd0, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 3'b100, 1'b0, 1'b0};
    vecs[7] = '{4'd9, 4'd3, 64'd7, 64'd9, 1'b1, 64'd0, 3'b100, 1'b1, 1'b1};
    vecs[8] = '{4'd1, 4'd7, 64'd5, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 1'b0, 1'b0};
    vecs[9] = '{4'd0, 4'd2, 64'd2, 64'd3, 1'b1, 64'd5, 3'b000, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    bubble = 1'b0;
    drive(4'd0, 4'd0, 64'd0, 64'd0, 1'b0);
    #12;
    rst = 1'b0;
    #1;
    chk("reset_cc", {61'd0, cc}, 64'd4);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_valE", valE, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors, one accepted transfer per cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].fun, vecs[i].cond, vecs[i].a, vecs[i].b, vecs[i].set_cc);
      step();
      $display("vec %0d fun=%0d cond=%0d valE=%0h cc=%b cnd=%0d err=%0d",
               i, vecs[i].fun, vecs[i].cond, valE, cc, cnd, err);
      chk($sformatf("vec%0d_valE", i), valE, vecs[i].exp_val);
      chk($sformatf("vec%0d_cc", i), {61'd0, cc}, {61'd0, vecs[i].exp_cc});
      chk($sformatf("vec%0d_cnd", i), {63'd0, cnd}, {63'd0, vecs[i].exp_cnd});
      chk($sformatf("vec%0d_err", i), {63'd0, err}, {63'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
    end

    // Back-pressure: result held while out_ready is low.
    drive(4'd0, 4'd0, 64'd1, 64'd2, 1'b0);
    step();
    chk("hold_first_valE", valE, 64'd3);
    out_ready = 1'b0;
    drive(4'd0, 4'd0, 64'd100, 64'd100, 1'b0);
    #1;
    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      $display("hold cycle %0d valE=%0h out_valid=%0d", i, valE, out_valid);
      chk("hold_valE", valE, 64'd3);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready_cyc", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("release_valE", valE, 64'd200);
    for (int i = 1; i <= 8; i++) begin
      drive(4'd0, 4'd0, 64'(i), 64'(i * 10), 1'b0);
      step();
      $display("stream %0d valE=%0d", i, valE);
      chk("stream_valE", valE, 64'(i * 11));
      chk("stream_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

    // Bubble: nothing accepted, flags untouched (an accepted xor 5^5 would set ZF).
    in_valid = 1'b1;
    drive(4'd0, 4'd0, 64'd1, 64'd1, 1'b0);
    step();
    chk("pre_bubble_out_valid", {63'd0, out_valid}, 64'd1);
    bubble = 1'b1;
    drive(4'd3, 4'd0, 64'd5, 64'd5, 1'b1);
    #1;
    chk("bubble_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    $display("bubble out_valid=%0d cc=%b", out_valid, cc);
    chk("bubble_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bubble_cc", {61'd0, cc}, 64'd0);
    bubble = 1'b0;

    // Asynchronous reset while a result is held.
    drive(4'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step();
    chk("prereset_cc", {61'd0, cc}, 64'd2);
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    chk("prereset_hold", {63'd0, out_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset out_valid=%0d cc=%b valE=%0h", out_valid, cc, valE);
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_cc", {61'd0, cc}, 64'd4);
    chk("async_rst_valE", valE, 64'd0);
    #1;
    rst = 1'b0;

    // Randomized run against the model.
    m_valid = 1'b0;
    m_val = '0;
    m_cnd = 1'b0;
    m_err = 1'b0;
    m_cc = 3'b100;
    delivered = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      bubble    = ($urandom_range(0, 9) == 0);
      alu_fun   = 4'($urandom_range(0, 5));
      cond_fun  = 4'($urandom_range(0, 8));
      set_cc    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: aluA = 64'h7FFF_FFFF_FFFF_FFFF;
        1: aluA = 64'h8000_0000_0000_0000;
        2: aluA = 64'd0;
        default: aluA = {$urandom, $urandom};
      endcase
      aluB = ($urandom_range(0, 4) == 0) ? aluA : {$urandom, $urandom};
      exp_rdy = !bubble && (!m_valid || out_ready);
      #1;
      chk("rand_in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      if (m_valid && out_ready && !bubble) delivered++;
      if (in_valid && exp_rdy) begin
        ref_alu(alu_fun, aluA, aluB, r, fl, ok);
        m_cnd = ref_cond(cond_fun, m_cc);
        m_val = r;
        m_err = !ok;
        m_valid = 1'b1;
        if (set_cc && ok) m_cc = fl;
      end else if (bubble || out_ready) begin
        m_valid = 1'b0;
      end
      step();
      chk("rand_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("rand_valE", valE, m_val);
      chk("rand_cnd", {63'd0, cnd}, {63'd0, m_cnd});
      chk("rand_err", {63'd0, err}, {63'd0, m_err});
      chk("rand_cc", {61'd0, cc}, {61'd0, m_cc});
    end
    $display("random run delivered %0d results", delivered);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
